pipeline_ctrl_unit: RTL

PIPELINE_CTRL_UNIT -- requirements
Module: pipeline_ctrl_unit

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/pipeline_ctrl_unit_if.sv | 41 ++++
 rtl/pipeline_ctrl_unit_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline control state and register-index width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef logic [4:0] regbits_t;

endpackage : cpu_types_pkg

// File: rtl/pipeline_ctrl_unit_if.sv
// Hazard inputs and per-register pipeline_ctrl outputs of pipeline_ctrl_unit.
// The datapath side uses the master modport; the control unit uses slave.
interface pipeline_ctrl_unit_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     dREN_MEM;
  logic     dWEN_MEM;
  regbits_t rs1_ID;
  regbits_t rs2_ID;
  regbits_t wsel_EX;
  logic     MemtoReg_EX;
  logic     RegWr_EX;
  logic     branch_taken_EX;
  logic     halt_MEM;

  logic     pc_en;
  logic     en_IFID;
  logic     en_IDEX;
  logic     en_EXMEM;
  logic     en_MEMWB;
  logic     flush_IFID;
  logic     flush_IDEX;
  logic     halt;

  modport master (
    output ihit, dhit, dREN_MEM, dWEN_MEM, rs1_ID, rs2_ID, wsel_EX,
           MemtoReg_EX, RegWr_EX, branch_taken_EX, halt_MEM,
    input  pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, halt
  );

  modport slave (
    input  ihit, dhit, dREN_MEM, dWEN_MEM, rs1_ID, rs2_ID, wsel_EX,
           MemtoReg_EX, RegWr_EX, branch_taken_EX, halt_MEM,
    output pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, halt
  );

endinterface : pipeline_ctrl_unit_if

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of
// the instruction in ID. Register 0 never creates a hazard.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  regbits_t rs1_ID,
  input  regbits_t rs2_ID,
  input  regbits_t wsel_EX,
  input  logic     MemtoReg_EX,
  input  logic     RegWr_EX,
  output logic     loaduse
);

  assign loaduse = MemtoReg_EX && RegWr_EX && (wsel_EX != '0) &&
                   ((wsel_EX == rs1_ID) || (wsel_EX == rs2_ID));

endmodule : hazard_detect

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control: freezes the pipe until fetch and data accesses are both
// done, inserts load-use bubbles, flushes on taken branches and halts.
// Optional macro PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt counter ports.
module pipeline_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
`endif
  pipeline_ctrl_unit_if.slave pif
);

  // Reject a counter width that cannot hold any count.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipeline_ctrl_unit: CNT_W must be at least 1");
  end

  pipe_state_t state, state_nxt;
  logic        ifetch_seen, dmem_seen;
  logic        dreq, fetch_ok, data_ok, advance, loaduse;

  // A hit that lands while the pipe is frozen is remembered in the sticky
  // flags, so the access is not repeated before the pipe advances.
  assign dreq     = pif.dREN_MEM | pif.dWEN_MEM;
  assign fetch_ok = pif.ihit | ifetch_seen;
  assign data_ok  = !dreq | pif.dhit | dmem_seen;
  assign advance  = fetch_ok && data_ok && (state != HALTED);

  hazard_detect u_hazard_detect (
    .rs1_ID      (pif.rs1_ID),
    .rs2_ID      (pif.rs2_ID),
    .wsel_EX     (pif.wsel_EX),
    .MemtoReg_EX (pif.MemtoReg_EX),
    .RegWr_EX    (pif.RegWr_EX),
    .loaduse     (loaduse)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  // Sticky hit flags: set while frozen, cleared on the advancing cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifetch_seen <= 1'b0;
      dmem_seen   <= 1'b0;
    end else if (advance) begin
      ifetch_seen <= 1'b0;
      dmem_seen   <= 1'b0;
    end else if (state != HALTED) begin
      ifetch_seen <= ifetch_seen | pif.ihit;
      dmem_seen   <= dmem_seen | pif.dhit;
    end
  end

  // Next state and register enables/flushes; a frozen pipe drives all zeros.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    pif.pc_en      = 1'b0;
    pif.en_IFID    = 1'b0;
    pif.en_IDEX    = 1'b0;
    pif.en_EXMEM   = 1'b0;
    pif.en_MEMWB   = 1'b0;
    pif.flush_IFID = 1'b0;
    pif.flush_IDEX = 1'b0;
    pif.halt       = 1'b0;
    case (state)
      HALTED: pif.halt = 1'b1;
      default: begin
        if (advance) begin
          // Halt wins the transition only; enables below still apply.
          state_nxt    = pif.halt_MEM ? HALTED : RUN;
          pif.en_IDEX  = 1'b1;
          pif.en_EXMEM = 1'b1;
          pif.en_MEMWB = 1'b1;
          if (pif.branch_taken_EX) begin
            pif.pc_en      = 1'b1;
            pif.en_IFID    = 1'b1;
            pif.flush_IFID = 1'b1;
            pif.flush_IDEX = 1'b1;
          end else if (loaduse) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            pif.flush_IDEX = 1'b1;
          end else begin
            pif.pc_en   = 1'b1;
            pif.en_IFID = 1'b1;
          end
        end else begin
          state_nxt = WAIT;
        end
      end
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc;

  assign stall_inc = (state != HALTED) &&
                     (!advance || (loaduse && !pif.branch_taken_EX));
  assign flush_inc = advance && pif.branch_taken_EX;

  // Wrapping performance counters for stalled and flushed cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule : pipeline_ctrl_unit
